// File: rtl/dcache_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_stage_if
// Purpose  : Request/response bus between the data cache and main memory.
// Revision : 1.0
// ============================================================================
interface dcache_mem_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dcache_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_stage
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache with
//            block fill on load miss, flush and saturating hit/miss counters.
// Revision : 1.0
// ============================================================================
module dcache_mem_stage #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 8,
    parameter int CNT_W       = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              op,
    input  wire logic              write,
    input  wire logic [ADDR_W-1:0] address_in,
    input  wire logic [DATA_W-1:0] data_in,
    input  wire logic              flush,
    output logic      [DATA_W-1:0] data_out,
    output logic                   stall,
    dcache_mem_stage_if.master     mem,
    output logic      [CNT_W-1:0]  hit_count,
    output logic      [CNT_W-1:0]  miss_count
);

    localparam int BPW    = DATA_W / 8;
    localparam int WOFF_W = $clog2(BPW);
    localparam int BO_W   = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = BO_W + WOFF_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

    localparam logic [0:0]        ST_IDLE      = 1'b0;
    localparam logic [0:0]        ST_FILL      = 1'b1;
    localparam logic [BO_W:0]     c_BLOCK_CNT  = (BO_W + 1)'(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(BPW - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [DATA_W-1:0] r_data [SETS][BLOCK_WORDS];
    logic [TAG_W-1:0]  r_fill_tag;
    logic [IDX_W-1:0]  r_fill_idx;
    logic [BO_W:0]     r_issue;
    logic [BO_W:0]     r_recv;
    logic              r_flush_pend;
    logic [CNT_W-1:0]  r_hit_count;
    logic [CNT_W-1:0]  r_miss_count;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [BO_W-1:0]   w_word;
    logic              w_hit;
    logic              w_load;
    logic              w_store;
    logic              w_issue_accept;
    logic              w_fill_done;
    logic [ADDR_W-1:0] w_fill_addr;

    assign w_idx   = address_in[OFF_W +: IDX_W];
    assign w_tag   = address_in[ADDR_W-1 -: TAG_W];
    assign w_word  = address_in[WOFF_W +: BO_W];
    assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_load  = op && !write;
    assign w_store = op && write;

    assign w_issue_accept = (r_state == ST_FILL) && (r_issue < c_BLOCK_CNT) && mem.mem_ready;
    assign w_fill_done    = (r_state == ST_FILL) && mem.mem_rvalid && (r_recv == c_BLOCK_CNT - 1'b1);
    assign w_fill_addr    = {r_fill_tag, r_fill_idx, {OFF_W{1'b0}}}
                          | (ADDR_W'(r_issue[BO_W-1:0]) << WOFF_W);

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_load && !w_hit) w_next_state = ST_FILL;
            ST_FILL: if (w_fill_done)      w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are forced low while rst is asserted so the reset is visible at once
    always_comb begin
        data_out      = '0;
        stall         = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_store) begin
                        mem.mem_req   = 1'b1;
                        mem.mem_we    = 1'b1;
                        mem.mem_addr  = address_in & c_ALIGN_MASK;
                        mem.mem_wdata = data_in;
                        stall         = !mem.mem_ready;
                    end else if (w_load) begin
                        if (w_hit) data_out = r_data[w_idx][w_word];
                        else       stall    = 1'b1;
                    end
                end
                ST_FILL: begin
                    stall        = 1'b1;
                    mem.mem_req  = (r_issue < c_BLOCK_CNT);
                    mem.mem_addr = w_fill_addr;
                end
                default: ;
            endcase
        end
    end

    // Control state: valid bits, fill bookkeeping, counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= '0;
            r_fill_tag   <= '0;
            r_fill_idx   <= '0;
            r_issue      <= '0;
            r_recv       <= '0;
            r_flush_pend <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load && w_hit && (r_hit_count != '1))
                        r_hit_count <= r_hit_count + 1'b1;
                    if (w_load && !w_hit) begin
                        if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
                        r_fill_tag <= w_tag;
                        r_fill_idx <= w_idx;
                        r_issue    <= '0;
                        r_recv     <= '0;
                    end
                    // The victim line is invalidated up front since its words are overwritten during the fill
                    if (flush)                 r_valid        <= '0;
                    else if (w_load && !w_hit) r_valid[w_idx] <= 1'b0;
                end
                ST_FILL: begin
                    if (w_issue_accept) r_issue      <= r_issue + 1'b1;
                    if (mem.mem_rvalid) r_recv       <= r_recv + 1'b1;
                    if (flush)          r_flush_pend <= 1'b1;
                    if (w_fill_done) begin
                        if (r_flush_pend || flush) r_valid             <= '0;
                        else                       r_valid[r_fill_idx] <= 1'b1;
                        r_flush_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; validity alone qualifies its contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((r_state == ST_FILL) && mem.mem_rvalid)
                r_data[r_fill_idx][r_recv[BO_W-1:0]] <= mem.mem_rdata;
            if (w_fill_done)
                r_tag[r_fill_idx] <= r_fill_tag;
            if ((r_state == ST_IDLE) && w_store && mem.mem_ready && w_hit)
                r_data[w_idx][w_word] <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_mem_stage
// Purpose  : Scoreboard bench for dcache_mem_stage with a latency memory model.
// Revision : 1.0
// ============================================================================
module tb_dcache_mem_stage;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;
    localparam int LAT    = 2;
    localparam int BOUND  = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op = 1'b0;
    logic              write = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] address_in = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              stall;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    dcache_mem_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    dcache_mem_stage #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(8), .BLOCK_WORDS(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .op(op), .write(write), .address_in(address_in),
        .data_in(data_in), .flush(flush), .data_out(data_out), .stall(stall),
        .mem(mem_if), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Memory model: initial contents are 0xA000 ^ byte address
    logic [DATA_W-1:0] mem_model [0:32767];
    typedef struct { logic [DATA_W-1:0] d; int due; } rsp_t;
    rsp_t rsp_q[$];
    rsp_t rsp_new;
    int   cyc = 0;

    always @(posedge clk) begin
        if (mem_if.mem_req && mem_if.mem_ready) begin
            if (mem_if.mem_we) begin
                mem_model[mem_if.mem_addr[15:1]] = mem_if.mem_wdata;
            end else begin
                rsp_new.d   = mem_model[mem_if.mem_addr[15:1]];
                rsp_new.due = cyc + LAT;
                rsp_q.push_back(rsp_new);
            end
        end
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_if.mem_rvalid <= 1'b1;
            mem_if.mem_rdata  <= rsp_q[0].d;
            void'(rsp_q.pop_front());
        end else begin
            mem_if.mem_rvalid <= 1'b0;
            mem_if.mem_rdata  <= '0;
        end
        cyc <= cyc + 1;
    end

    // Scoreboard queues and monitor
    logic [15:0] exp_rd[$];
    logic [15:0] exp_load[$];
    logic [31:0] exp_wr[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_if.mem_req && mem_if.mem_ready) begin
                if (mem_if.mem_we) begin
                    if (exp_wr.size() == 0) check("spurious_write", {mem_if.mem_addr, mem_if.mem_wdata}, 32'(exp_wr.size()));
                    else check("mem_write", {mem_if.mem_addr, mem_if.mem_wdata}, exp_wr.pop_front());
                end else begin
                    if (exp_rd.size() == 0) check("spurious_read", 32'(mem_if.mem_addr), 32'(exp_rd.size()) - 1);
                    else check("fill_addr", 32'(mem_if.mem_addr), 32'(exp_rd.pop_front()));
                end
            end
            if (op && !write && !stall) begin
                if (exp_load.size() == 0) check("spurious_load", 32'(data_out), 32'(exp_load.size()) - 1);
                else check($sformatf("load_data@%h", address_in), 32'(data_out), 32'(exp_load.pop_front()));
            end
        end
    end

    logic [CNT_W-1:0] exp_hit  = '0;
    logic [CNT_W-1:0] exp_miss = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    task automatic load(input logic [15:0] a, input logic [15:0] d, input int fills, input int flush_at);
        int n;
        bit done;
        for (int f = 0; f < fills; f++)
            for (int i = 0; i < 8; i++) exp_rd.push_back((a & 16'hFFF0) + 16'(2 * i));
        exp_load.push_back(d);
        op = 1'b1; write = 1'b0; address_in = a;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!stall || n > BOUND) done = 1'b1;
            else begin
                n++;
                @(posedge clk); #1;
                flush = (n == flush_at);
            end
        end
        check($sformatf("load_timeout@%h", a), 32'(n > BOUND), 32'(0));
        check($sformatf("miss_stall@%h", a), 32'(n > 0), 32'(fills > 0));
        for (int f = 0; f < fills; f++) exp_miss = sat_inc(exp_miss);
        exp_hit = sat_inc(exp_hit);
        @(posedge clk); #1;
        op = 1'b0; flush = 1'b0;
        check("hit_count", 32'(hit_count), 32'(exp_hit));
        check("miss_count", 32'(miss_count), 32'(exp_miss));
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input int low);
        exp_wr.push_back({a & 16'hFFFE, d});
        op = 1'b1; write = 1'b1; address_in = a; data_in = d;
        mem_if.mem_ready = 1'b0;
        for (int i = 0; i < low; i++) begin
            @(negedge clk);
            check("store_stall_held", 32'(stall), 32'(1));
            @(posedge clk); #1;
        end
        mem_if.mem_ready = 1'b1;
        @(negedge clk);
        check("store_stall_released", 32'(stall), 32'(0));
        @(posedge clk); #1;
        op = 1'b0; write = 1'b0;
        check("store_hit_count", 32'(hit_count), 32'(exp_hit));
        check("store_miss_count", 32'(miss_count), 32'(exp_miss));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'hA000 ^ 16'(i * 2);
        mem_if.mem_ready = 1'b1;
        rst = 1'b1;
        op = 1'b1; address_in = 16'h0000;
        #12;
        check("rst_stall", 32'(stall), 32'(0));
        check("rst_mem_req", 32'(mem_if.mem_req), 32'(0));
        check("rst_data_out", 32'(data_out), 32'(0));
        check("rst_counters", {16'(hit_count), 16'(miss_count)}, 32'(0));
        op = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        load(16'h0000, 16'hA000, 1, -1);
        load(16'h000A, 16'hA00A, 0, -1);
        load(16'hFFFE, 16'h5FFE, 1, -1);
        load(16'h0080, 16'hA080, 1, -1);
        load(16'h0000, 16'hA000, 1, -1);
        load(16'h8000, 16'h2000, 1, -1);
        load(16'hFFFE, 16'h5FFE, 0, -1);
        load(16'h0000, 16'hA000, 1, -1);

        store(16'h0005, 16'hBEEF, 2);
        load(16'h0004, 16'hBEEF, 0, -1);
        store(16'h0100, 16'h1234, 0);
        load(16'h0100, 16'h1234, 1, -1);

        load(16'h0210, 16'hA210, 2, 3);
        load(16'h0210, 16'hA210, 0, -1);
        load(16'hFFFE, 16'h5FFE, 1, -1);

        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        load(16'h0210, 16'hA210, 1, -1);

        // Reset in the middle of a fill
        for (int i = 0; i < 8; i++) exp_rd.push_back(16'h0300 + 16'(2 * i));
        op = 1'b1; write = 1'b0; address_in = 16'h0300;
        repeat (4) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        check("midrst_stall", 32'(stall), 32'(0));
        check("midrst_mem_req", 32'(mem_if.mem_req), 32'(0));
        check("midrst_mem_addr", 32'(mem_if.mem_addr), 32'(0));
        check("midrst_data_out", 32'(data_out), 32'(0));
        check("midrst_counters", {16'(hit_count), 16'(miss_count)}, 32'(0));
        op = 1'b0;
        exp_rd.delete();
        exp_load.delete();
        exp_hit = '0; exp_miss = '0;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 20 && rsp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        load(16'h0300, 16'hA300, 1, -1);

        // Counter saturation through repeated conflict misses
        for (int i = 0; i < 34; i++) begin
            if (i % 2 == 0) load(16'h0400, 16'hA400, 1, -1);
            else            load(16'h0480, 16'hA480, 1, -1);
        end
        check("miss_saturated", 32'(miss_count), 32'(31));
        check("hit_saturated", 32'(hit_count), 32'(31));

        repeat (5) @(posedge clk);
        #1;
        check("pending_reads", 32'(exp_rd.size()), 32'(0));
        check("pending_loads", 32'(exp_load.size()), 32'(0));
        check("pending_writes", 32'(exp_wr.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
